// File: rtl/hdc_feature_collector_if.sv
// ============================================================================
// Module      : hdc_feature_collector_if
// Description : Sample-in / frame-out handshake bundle for the HDC feature
//               collector. The slave modport is the collector side, the
//               master modport is the producer/consumer environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

interface hdc_feature_collector_if #(
  parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
);
  logic [CHANNEL_WIDTH-1:0]             sin_data;
  logic                                 sin_valid;
  logic                                 sin_ready;
  logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top;
  logic                                 fout_valid;
  logic                                 fout_ready;

  modport slave (
    input  sin_data,
    input  sin_valid,
    output sin_ready,
    output features_top,
    output fout_valid,
    input  fout_ready
  );

  modport master (
    output sin_data,
    output sin_valid,
    input  sin_ready,
    input  features_top,
    input  fout_valid,
    output fout_ready
  );
endinterface

`default_nettype wire

// File: rtl/hdc_feature_collector.sv
// ============================================================================
// Module      : hdc_feature_collector
// Description : Serial-to-parallel collector feeding hdc_sensor_fusion. Packs
//               NUM_CHANNEL samples (first sample MSB-most) into one frame,
//               with one assembly register and one output register so that
//               collection of the next frame overlaps output of the current.
//               Optional macro HDC_COLLECTOR_LAST_CHECK_EN adds sin_last /
//               frame_err framing check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module hdc_feature_collector #(
  parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hdc_feature_collector_if.slave bus,
  output logic [CNT_WIDTH-1:0]  frame_count
`ifdef HDC_COLLECTOR_LAST_CHECK_EN
  ,
  input  logic                  sin_last,
  output logic                  frame_err
`endif
);

  localparam int IDX_W  = $clog2(NUM_CHANNEL);
  localparam int FEAT_W = NUM_CHANNEL * CHANNEL_WIDTH;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CHANNEL - 1);

  // COLLECT: accepting samples; HOLD: complete frame parked in the assembly
  // register waiting for the output register to free up.
  localparam logic [0:0] c_ST_COLLECT = 1'b0;
  localparam logic [0:0] c_ST_HOLD    = 1'b1;

  logic [0:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [FEAT_W-1:0]    r_asm;
  logic [FEAT_W-1:0]    r_out;
  logic                 r_fout_valid;
  logic [CNT_WIDTH-1:0] r_frame_count;

  logic [FEAT_W-1:0]    w_asm_next;
  logic                 w_accept;
  logic                 w_slot_free;
  logic                 w_is_last;
  logic                 w_bad;

  // Ready depends only on registered state, never on sin_valid or fout_ready.
  assign bus.sin_ready    = (r_state == c_ST_COLLECT);
  assign bus.features_top = r_out;
  assign bus.fout_valid   = r_fout_valid;
  assign frame_count      = r_frame_count;

  assign w_accept    = bus.sin_valid && (r_state == c_ST_COLLECT);
  assign w_slot_free = !r_fout_valid || bus.fout_ready;
  assign w_is_last   = (r_idx == c_LAST_IDX);

`ifdef HDC_COLLECTOR_LAST_CHECK_EN
  // Framing error: sin_last must coincide exactly with the final channel.
  assign w_bad = (sin_last != w_is_last);
`else
  assign w_bad = 1'b0;
`endif

  // Assembly word with the current sample merged into slot r_idx.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_asm_next[(NUM_CHANNEL-1-k)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = bus.sin_data;
      end
    end
  end

  // Collection state machine, output register and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_ST_COLLECT;
      r_idx         <= '0;
      r_asm         <= '0;
      r_out         <= '0;
      r_fout_valid  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // Downstream handshake frees the slot; a frame loaded below overrides.
      if (r_fout_valid && bus.fout_ready) begin
        r_fout_valid <= 1'b0;
      end

      case (r_state)
        c_ST_COLLECT: begin
          if (w_accept) begin
            if (w_bad) begin
              r_idx <= '0;
            end else if (w_is_last) begin
              r_idx <= '0;
              if (w_slot_free) begin
                r_out         <= w_asm_next;
                r_fout_valid  <= 1'b1;
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
              end else begin
                r_asm   <= w_asm_next;
                r_state <= c_ST_HOLD;
              end
            end else begin
              r_asm <= w_asm_next;
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        c_ST_HOLD: begin
          if (w_slot_free) begin
            r_out         <= r_asm;
            r_fout_valid  <= 1'b1;
            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
            r_idx         <= '0;
            r_state       <= c_ST_COLLECT;
          end
        end

        default: r_state <= c_ST_COLLECT;
      endcase
    end
  end

`ifdef HDC_COLLECTOR_LAST_CHECK_EN
  logic r_frame_err;

  // One-cycle error pulse for every accepted beat that breaks framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept && w_bad;
    end
  end

  assign frame_err = r_frame_err;
`endif

endmodule

`default_nettype wire

// File: doc/hdc_feature_collector.md
# hdc_feature_collector

Serial-to-parallel feature collector placed directly upstream of `hdc_sensor_fusion`. Accepts one channel sample per beat over a valid/ready stream, assembles a full frame of `NUM_CHANNEL` samples and presents it as the `features_top` word with a `fin_valid`/`fin_ready`-compatible output handshake. It has one assembly register and one output register, so collection of frame N+1 overlaps consumption of frame N.

## Interface
- `NUM_CHANNEL`, default `` `TOTAL_NUM_CHANNEL ``: samples per frame, ≥2.
- `CHANNEL_WIDTH`, default `` `CHANNEL_WIDTH ``: bits per sample.
- `CNT_WIDTH`, default 16: width of the frame counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sin_data`  in  `CHANNEL_WIDTH`  one channel sample.
- `sin_valid`  in  1  sample valid.
- `sin_ready`  out  1  collector can accept a sample.
- `features_top`  out  `NUM_CHANNEL*CHANNEL_WIDTH`  assembled frame; drives `hdc_sensor_fusion.features_top`.
- `fout_valid`  out  1  frame valid; drives `fin_valid`.
- `fout_ready`  in  1  downstream accepts; driven by `fin_ready`.
- `frame_count`  out  `CNT_WIDTH`  frames handed downstream, wraps at 2^`CNT_WIDTH`.
- `sin_last`  in  1  present only with `HDC_COLLECTOR_LAST_CHECK_EN`.
- `frame_err`  out  1  present only with `HDC_COLLECTOR_LAST_CHECK_EN`.

## Operation
- Beat accepted when `sin_valid && sin_ready`. Channel index `idx` (0..`NUM_CHANNEL`-1) starts at 0. An accepted beat writes slot `idx`, then `idx` increments.
- Packing: slot k occupies bits `[(NUM_CHANNEL-k)*CHANNEL_WIDTH-1 : (NUM_CHANNEL-k-1)*CHANNEL_WIDTH]`. The first sample is MSB-most, matching the feature text-file order.
- Output slot is free when `!fout_valid || fout_ready`.
- Beat at `idx==NUM_CHANNEL-1`, slot free:
  - the assembled word, including this beat, loads `features_top` at the same edge;
  - `fout_valid` is set, `idx` returns to 0, `frame_count` increments.
- Beat at `idx==NUM_CHANNEL-1`, slot not free:
  - the word stays in the assembly register and `asm_full` is set;
  - `sin_ready` is 0 while `asm_full` is set.
- While `asm_full`: on the first cycle the slot is free, the assembly word loads `features_top`, `fout_valid` is 1, `asm_full` clears, `idx` is 0 and `frame_count` increments.
- Output handshake with no new frame loading: `fout_valid && fout_ready` clears `fout_valid`.
- `sin_ready = !asm_full`. There is no combinational path from `sin_valid` to `sin_ready`. `fout_ready` → `sin_ready` only through registered `asm_full`.
- `features_top` stays stable while `fout_valid && !fout_ready`.
- States (`idx` and `asm_full` together):
  - COLLECT (`asm_full`=0): goes to HOLD on the last beat with the slot busy.
  - HOLD (`asm_full`=1): goes to COLLECT when the slot is free.

## Timing
- Reset values: `sin_ready`=1, `fout_valid`=0, `features_top`=0, `frame_count`=0, `frame_err`=0. Internally `idx`=0, `asm_full`=0.
- Reset mid-frame discards the partial frame and any held or output frame.
- Latency: `fout_valid` is high the cycle after the last beat is accepted, when the slot is free.
- Throughput: one sample per cycle sustained when `fout_ready` is held high. There are no bubbles between frames.
- Simultaneous output handshake and last-beat acceptance: the new frame replaces the old in the same edge, and `fout_valid` stays 1.
- HOLD → COLLECT: `sin_ready` rises the cycle after the slot is free. The first beat of the next frame can be accepted that cycle.
- `frame_count` wraps from 2^`CNT_WIDTH`-1 to 0.

## Configuration
- `HDC_COLLECTOR_LAST_CHECK_EN` defined adds the `sin_last` and `frame_err` ports and this check on each accepted beat:
  - `sin_last==1` with `idx!=NUM_CHANNEL-1`: the partial frame is dropped, `idx` returns to 0, `frame_err` pulses for 1 cycle.
  - `sin_last==0` with `idx==NUM_CHANNEL-1`: the beat is discarded, the frame is dropped, `idx` returns to 0, `frame_err` pulses for 1 cycle.
  - A dropped frame never reaches the output and does not increment `frame_count`.
- Undefined: no `sin_last` or `frame_err` ports. Frame boundaries come only from the beat count.

## Test plan
All with `NUM_CHANNEL`=4, `CHANNEL_WIDTH`=8.
- Reset, then beats 0x11,0x22,0x33,0x44 with `fout_ready`=1 → `features_top`=0x11223344 and `fout_valid`=1 exactly 1 cycle after the 4th beat; `frame_count`=1.
- Back-to-back frames 0x11223344 and 0x55667788 with `sin_valid` and `fout_ready` held 1 → 8 consecutive beats accepted, `sin_ready` never 0, `fout_valid` high on cycles 4 and 8 after start.
- `fout_ready`=0, send two full frames → second frame's last beat accepted, then `sin_ready`=0. Frame 1 stays on `features_top`. Raise `fout_ready` for 1 cycle → frame 2 appears the next cycle and `sin_ready` returns to 1.
- Assert `rst` asynchronously after 2 beats (mid-clock) → `fout_valid`=0 and `sin_ready`=1 immediately. The next 4 beats 0xA1..0xA4 give 0xA1A2A3A4.
- Preload `frame_count` to 0xFFFF via 65535 frames (or force), send one more frame → `frame_count`=0x0000.
- With `HDC_COLLECTOR_LAST_CHECK_EN`: `sin_last`=1 on beat 2 → `frame_err` pulses 1 cycle, no `fout_valid`. A following correct 4-beat frame is output unchanged.
